mcpu_soc_i2c_target: RTL and testbench

- I2C target (slave) responder: the other end of the SoC's I2C master link.
- Exposes a small byte register bank to an external I2C master, or to our own master in loopback for board bring-up and self-test.
- The CPU reads and writes the same bank through the MMIO decoder using the standard data_in/addr/write_en/data_out peripheral port.
- Runs entirely in the core clock domain, oversampling SCL/SDA.

---
 rtl/mcpu_soc_i2c_pkg.sv | 32 +++
 rtl/mcpu_soc_i2c_pin_sync.sv | 70 +++++++
 rtl/mcpu_soc_i2c_target.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mcpu_soc_i2c_target.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mcpu_soc_i2c_pkg.sv
// Shared definitions for the SoC I2C link: the target state encoding, bus
// level constants for ACK/NACK and the R/W bit, and a small shift helper.
// Shared by the target RTL, the master and the testbenches.
package mcpu_soc_i2c_pkg;

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    ADDR      = 4'd1,
    ADDR_ACK  = 4'd2,
    PTR       = 4'd3,
    PTR_ACK   = 4'd4,
    WDATA     = 4'd5,
    WDATA_ACK = 4'd6,
    RDATA     = 4'd7,
    RDATA_ACK = 4'd8,
    IGNORE    = 4'd9
  } i2c_state_e;

  // SDA level in the acknowledge slot
  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  // Meaning of bit 0 of the address byte
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

  // Append one received bit to a byte, MSB first
  function automatic logic [7:0] shift_in(input logic [7:0] cur, input logic b);
    return {cur[6:0], b};
  endfunction

endpackage

// File: rtl/mcpu_soc_i2c_pin_sync.sv
// SCL/SDA input conditioning for the I2C target.
// Each pin goes through a 2-flop synchroniser (preset high, the idle bus
// level) and one delay stage; the edge/START/STOP events are registered, so
// each fires for one cycle, 3 core cycles after the pin transition.
// Ports:
//   clk, rst_n  core clock, asynchronous active-low reset
//   scl_in      raw SCL pin
//   sda_in      raw SDA pin
//   scl_rise    one-cycle pulse on SCL rising edge
//   scl_fall    one-cycle pulse on SCL falling edge
//   start       one-cycle pulse on SDA fall while SCL high
//   stop        one-cycle pulse on SDA rise while SCL high
//   sda_bit     synchronised SDA level aligned with the events
module mcpu_soc_i2c_pin_sync
  import mcpu_soc_i2c_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic scl_in,
  input  logic sda_in,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_bit
);

  logic [1:0] scl_sync_r;
  logic [1:0] sda_sync_r;
  logic       scl_dly_r;
  logic       sda_dly_r;
  logic       scl_rise_r;
  logic       scl_fall_r;
  logic       start_r;
  logic       stop_r;
  logic       sda_bit_r;

  // Synchronisers, delay stage and registered event detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      scl_dly_r  <= 1'b1;
      sda_dly_r  <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
      sda_bit_r  <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[0], scl_in};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      scl_dly_r  <= scl_sync_r[1];
      sda_dly_r  <= sda_sync_r[1];
      scl_rise_r <= scl_sync_r[1] & ~scl_dly_r;
      scl_fall_r <= ~scl_sync_r[1] & scl_dly_r;
      // SCL must be high both before and after the SDA change
      start_r    <= scl_sync_r[1] & scl_dly_r & ~sda_sync_r[1] & sda_dly_r;
      stop_r     <= scl_sync_r[1] & scl_dly_r & sda_sync_r[1] & ~sda_dly_r;
      sda_bit_r  <= sda_sync_r[1];
    end
  end

  assign scl_rise = scl_rise_r;
  assign scl_fall = scl_fall_r;
  assign start    = start_r;
  assign stop     = stop_r;
  assign sda_bit  = sda_bit_r;

endmodule

// File: rtl/mcpu_soc_i2c_target.sv
// I2C target (slave) exposing a small byte register bank.
// An I2C master writes a pointer byte then data bytes, or reads bytes from the
// current pointer; the CPU reads/writes the same bank through a word port.
// Everything runs in the core clock domain by oversampling SCL/SDA.
// Ports:
//   clkrst_core_clk    core clock (>= 16x SCL)
//   clkrst_core_rst_n  asynchronous active-low reset
//   addr               CPU word index into the bank
//   data_in            CPU write data
//   write_en           CPU byte-lane write enables
//   data_out           bank word at addr (combinational, little-endian)
//   scl_in, sda_in     raw I2C pins
//   sda_oe             1 = pull SDA low
//   wr_strobe          one-cycle pulse when an I2C write commits a byte
//   busy               high while this target is addressed, until STOP
module mcpu_soc_i2c_target
  import mcpu_soc_i2c_pkg::*;
#(
  parameter logic [6:0] TARGET_ADDR = 7'h42,
  parameter int         NBYTES      = 8,
  parameter int         AW          = $clog2(NBYTES / 4)
) (
  input  logic          clkrst_core_clk,
  input  logic          clkrst_core_rst_n,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   data_in,
  input  logic [3:0]    write_en,
  output logic [31:0]   data_out,
  input  logic          scl_in,
  input  logic          sda_in,
  output logic          sda_oe,
  output logic          wr_strobe,
  output logic          busy
);

  localparam int            PW      = $clog2(NBYTES);
  localparam logic [PW-1:0] PTR_INC = PW'(1'b1);

  logic scl_rise_s;
  logic scl_fall_s;
  logic start_s;
  logic stop_s;
  logic sda_bit_s;

  i2c_state_e    state_r, state_n;
  logic [2:0]    bitcnt_r, bitcnt_n;
  logic [7:0]    shift_r, shift_n;
  logic [PW-1:0] ptr_r, ptr_n;
  logic          rw_r, rw_n;
  logic          sda_oe_r, sda_oe_n;
  logic          busy_r, busy_n;
  logic          phase_r, phase_n;
  logic          wr_strobe_r;
  logic          commit_s;
  logic [7:0]    rx_byte_s;
  logic [7:0]    rd_byte_s;
  logic          last_bit_s;

  logic [7:0]        bank_r [NBYTES];
  logic [NBYTES-1:0] cpu_we_s;

  mcpu_soc_i2c_pin_sync u_pin_sync (
    .clk      (clkrst_core_clk),
    .rst_n    (clkrst_core_rst_n),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start    (start_s),
    .stop     (stop_s),
    .sda_bit  (sda_bit_s)
  );

  assign rx_byte_s  = shift_in(shift_r, sda_bit_s);
  assign rd_byte_s  = bank_r[ptr_r];
  assign last_bit_s = (bitcnt_r == 3'd7);

  // State register
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Next-state and datapath decode; START/STOP override every state
  always_comb begin
    state_n  = state_r;
    bitcnt_n = bitcnt_r;
    shift_n  = shift_r;
    ptr_n    = ptr_r;
    rw_n     = rw_r;
    sda_oe_n = sda_oe_r;
    busy_n   = busy_r;
    phase_n  = phase_r;
    commit_s = 1'b0;
    if (stop_s) begin
      state_n  = IDLE;
      bitcnt_n = 3'd0;
      sda_oe_n = 1'b0;
      busy_n   = 1'b0;
      phase_n  = 1'b0;
    end else if (start_s) begin
      state_n  = ADDR;
      bitcnt_n = 3'd0;
      sda_oe_n = 1'b0;
      phase_n  = 1'b0;
    end else begin
      case (state_r)
        IDLE, IGNORE: begin
          sda_oe_n = 1'b0;
        end
        ADDR, PTR, WDATA: begin
          if (scl_rise_s) begin
            shift_n = rx_byte_s;
            if (last_bit_s) begin
              bitcnt_n = 3'd0;
              case (state_r)
                ADDR: begin
                  if (rx_byte_s[7:1] == TARGET_ADDR) begin
                    state_n = ADDR_ACK;
                    rw_n    = rx_byte_s[0];
                  end else begin
                    state_n = IGNORE;
                    busy_n  = 1'b0;
                  end
                end
                PTR: begin
                  // upper pointer-byte bits are discarded
                  ptr_n   = rx_byte_s[PW-1:0];
                  state_n = PTR_ACK;
                end
                default: begin
                  commit_s = 1'b1;
                  ptr_n    = ptr_r + PTR_INC;
                  state_n  = WDATA_ACK;
                end
              endcase
            end else begin
              bitcnt_n = bitcnt_r + 3'd1;
            end
          end else begin
            shift_n = shift_r;
          end
        end
        ADDR_ACK, PTR_ACK, WDATA_ACK: begin
          // sda_oe low on a fall means the byte just ended: start the ACK;
          // sda_oe high means this fall ends the ACK slot.
          if (scl_fall_s) begin
            if (!sda_oe_r) begin
              sda_oe_n = 1'b1;
              busy_n   = 1'b1;
            end else if ((state_r == ADDR_ACK) && (rw_r == RW_READ)) begin
              state_n  = RDATA;
              shift_n  = rd_byte_s;
              sda_oe_n = ~rd_byte_s[7];
            end else if (state_r == ADDR_ACK) begin
              state_n  = PTR;
              sda_oe_n = 1'b0;
            end else begin
              state_n  = WDATA;
              sda_oe_n = 1'b0;
            end
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        RDATA: begin
          if (scl_rise_s) begin
            shift_n = {shift_r[6:0], 1'b0};
            if (last_bit_s) begin
              bitcnt_n = 3'd0;
              state_n  = RDATA_ACK;
            end else begin
              bitcnt_n = bitcnt_r + 3'd1;
            end
          end else if (scl_fall_s) begin
            sda_oe_n = ~shift_r[7];
          end else begin
            sda_oe_n = sda_oe_r;
          end
        end
        RDATA_ACK: begin
          // first fall releases SDA; rise samples the master; the fall
          // after an ACK loads the next byte (captured at this moment)
          if (scl_rise_s) begin
            if (sda_bit_s == ACK) begin
              ptr_n   = ptr_r + PTR_INC;
              phase_n = 1'b1;
            end else begin
              state_n = IGNORE;
            end
          end else if (scl_fall_s) begin
            if (phase_r) begin
              phase_n  = 1'b0;
              state_n  = RDATA;
              shift_n  = rd_byte_s;
              sda_oe_n = ~rd_byte_s[7];
            end else begin
              sda_oe_n = 1'b0;
            end
          end else begin
            phase_n = phase_r;
          end
        end
        default: begin
          state_n  = IDLE;
          sda_oe_n = 1'b0;
        end
      endcase
    end
  end

  // Datapath registers and output strobes
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      bitcnt_r    <= 3'd0;
      shift_r     <= 8'd0;
      ptr_r       <= '0;
      rw_r        <= RW_WRITE;
      sda_oe_r    <= 1'b0;
      busy_r      <= 1'b0;
      phase_r     <= 1'b0;
      wr_strobe_r <= 1'b0;
    end else begin
      bitcnt_r    <= bitcnt_n;
      shift_r     <= shift_n;
      ptr_r       <= ptr_n;
      rw_r        <= rw_n;
      sda_oe_r    <= sda_oe_n;
      busy_r      <= busy_n;
      phase_r     <= phase_n;
      wr_strobe_r <= commit_s;
    end
  end

  // CPU byte-lane decode
  for (genvar g = 0; g < NBYTES; g++) begin : g_cpu_we
    assign cpu_we_s[g] = write_en[g % 4] && (addr == AW'(g / 4));
  end

  // Register bank; a CPU write beats an I2C commit to the same byte
  always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
    if (!clkrst_core_rst_n) begin
      for (int k = 0; k < NBYTES; k++) begin
        bank_r[k] <= 8'd0;
      end
    end else begin
      for (int k = 0; k < NBYTES; k++) begin
        if (cpu_we_s[k]) begin
          bank_r[k] <= data_in[8*(k%4) +: 8];
        end else if (commit_s && (ptr_r == PW'(k))) begin
          bank_r[k] <= rx_byte_s;
        end else begin
          bank_r[k] <= bank_r[k];
        end
      end
    end
  end

  assign data_out  = {bank_r[{addr, 2'd3}], bank_r[{addr, 2'd2}],
                      bank_r[{addr, 2'd1}], bank_r[{addr, 2'd0}]};
  assign sda_oe    = sda_oe_r;
  assign wr_strobe = wr_strobe_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_mcpu_soc_i2c_target.sv
// Directed bench for mcpu_soc_i2c_target: the bench plays the I2C master
// (open-drain SDA wired-AND with the target) and the CPU port.
module tb_mcpu_soc_i2c_target;
  import mcpu_soc_i2c_pkg::*;

  localparam int AW = 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] addr;
  logic [31:0]   data_in;
  logic [3:0]    write_en;
  logic [31:0]   data_out;
  logic          scl_m;
  logic          sda_m;
  logic          sda_line;
  logic          sda_oe;
  logic          wr_strobe;
  logic          busy;

  int n_checks = 0;
  int n_fail = 0;
  int strobe_cnt = 0;

  assign sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  mcpu_soc_i2c_target #(.TARGET_ADDR(7'h42), .NBYTES(8)) dut (
    .clkrst_core_clk   (clk),
    .clkrst_core_rst_n (rst_n),
    .addr              (addr),
    .data_in           (data_in),
    .write_en          (write_en),
    .data_out          (data_out),
    .scl_in            (scl_m),
    .sda_in            (sda_line),
    .sda_oe            (sda_oe),
    .wr_strobe         (wr_strobe),
    .busy              (busy)
  );

  // count commit pulses away from the active edge
  always @(negedge clk) begin
    if (rst_n && wr_strobe) strobe_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_word(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    addr = a;
    #1;
    check_eq(tag, data_out, exp);
  endtask

  task automatic cpu_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] we);
    @(negedge clk);
    addr = a; data_in = d; write_en = we;
    @(negedge clk);
    write_en = 4'h0;
  endtask

  task automatic bus_start();
    if (!scl_m) begin
      wait_neg(4); sda_m = 1'b1;
      wait_neg(4); scl_m = 1'b1;
      wait_neg(8);
    end
    sda_m = 1'b0;
    wait_neg(8); scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    wait_neg(4); sda_m = 1'b0;
    wait_neg(4); scl_m = 1'b1;
    wait_neg(8); sda_m = 1'b1;
    wait_neg(8);
  endtask

  task automatic send_bit(input logic b);
    wait_neg(4); sda_m = b;
    wait_neg(4); scl_m = 1'b1;
    wait_neg(8); scl_m = 1'b0;
  endtask

  // Send a bit whose rising edge commits a byte; a CPU write of 0xFF to
  // bank[0] is placed on the exact commit clock edge (4th posedge after SCL).
  task automatic send_bit_collide(input logic b);
    wait_neg(4); sda_m = b;
    wait_neg(4); scl_m = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    addr = 1'b0; data_in = 32'h000000FF; write_en = 4'h1;
    @(posedge clk);
    @(negedge clk);
    write_en = 4'h0;
    check_eq("collide_strobe", {31'd0, wr_strobe}, 32'd1);
    wait_neg(4); scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b, output logic oe);
    wait_neg(4); sda_m = 1'b1;
    wait_neg(4); scl_m = 1'b1;
    wait_neg(4); b = sda_line; oe = sda_oe;
    wait_neg(4); scl_m = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack_line);
    logic oe;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(ack_line, oe);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic mack);
    logic b, oe;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b, oe);
      d[i] = b;
    end
    send_bit(mack);
  endtask

  initial begin
    logic       a;
    logic [7:0] rd;
    scl_m = 1'b1; sda_m = 1'b1;
    addr = '0; data_in = 32'd0; write_en = 4'h0;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(4);

    // reset state
    check_word(1'b0, 32'h0, "rst_word0");
    check_word(1'b1, 32'h0, "rst_word1");
    check_eq("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_strobe", {31'd0, wr_strobe}, 32'd0);

    // master write: ptr 2, A5, 3C
    bus_start();
    send_byte(8'h84, a); check_eq("t1_addr_ack", {31'd0, a}, {31'd0, ACK});
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h02, a); check_eq("t1_ptr_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'hA5, a); check_eq("t1_d0_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'h3C, a); check_eq("t1_d1_ack", {31'd0, a}, {31'd0, ACK});
    bus_stop();
    check_word(1'b0, 32'h3CA50000, "t1_word0");
    check_eq("t1_strobes", strobe_cnt, 32'd2);
    check_eq("t1_busy_end", {31'd0, busy}, 32'd0);

    // CPU write word 1, then current-address read proves pointer is 4
    cpu_write(1'b1, 32'h11223344, 4'hF);
    check_word(1'b1, 32'h11223344, "t2_cpu_word1");
    bus_start();
    send_byte(8'h85, a); check_eq("t2_cur_addr_ack", {31'd0, a}, {31'd0, ACK});
    recv_byte(rd, NACK); check_eq("t2_cur_read_ptr4", {24'd0, rd}, 32'h44);
    bus_stop();

    // bank[0]=0x44, then ptr 7 read with wrap to 0
    cpu_write(1'b0, 32'h00000044, 4'h1);
    check_word(1'b0, 32'h3CA50044, "t2_cpu_word0");
    bus_start();
    send_byte(8'h84, a); check_eq("t2_addr_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'h07, a); check_eq("t2_ptr_ack", {31'd0, a}, {31'd0, ACK});
    bus_start();
    send_byte(8'h85, a); check_eq("t2_raddr_ack", {31'd0, a}, {31'd0, ACK});
    recv_byte(rd, ACK); check_eq("t2_read_b7", {24'd0, rd}, 32'h11);
    check_eq("t2_busy", {31'd0, busy}, 32'd1);
    recv_byte(rd, NACK); check_eq("t2_read_wrap", {24'd0, rd}, 32'h44);
    bus_stop();
    check_eq("t2_busy_end", {31'd0, busy}, 32'd0);
    check_eq("t2_strobes", strobe_cnt, 32'd2);

    // wrong address 0x43: no ACK, bank untouched
    bus_start();
    send_byte(8'h86, a); check_eq("t3_addr_nack", {31'd0, a}, {31'd0, NACK});
    check_eq("t3_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00, a); check_eq("t3_ptr_nack", {31'd0, a}, {31'd0, NACK});
    send_byte(8'h00, a); check_eq("t3_data_nack", {31'd0, a}, {31'd0, NACK});
    check_eq("t3_state", 32'(dut.state_r), 32'(IGNORE));
    bus_stop();
    check_word(1'b0, 32'h3CA50044, "t3_word0");
    check_eq("t3_strobes", strobe_cnt, 32'd2);

    // STOP after 4 data bits: no commit
    bus_start();
    send_byte(8'h84, a); check_eq("t4_addr_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'h01, a); check_eq("t4_ptr_ack", {31'd0, a}, {31'd0, ACK});
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_stop();
    check_word(1'b0, 32'h3CA50044, "t4_word0");
    check_eq("t4_strobes", strobe_cnt, 32'd2);
    check_eq("t4_state", 32'(dut.state_r), 32'(IDLE));
    check_eq("t4_busy", {31'd0, busy}, 32'd0);

    // same-cycle CPU write 0xFF and I2C commit 0x00 to bank[0]
    bus_start();
    send_byte(8'h84, a); check_eq("t5_addr_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'h00, a); check_eq("t5_ptr_ack", {31'd0, a}, {31'd0, ACK});
    for (int i = 0; i < 7; i++) send_bit(1'b0);
    send_bit_collide(1'b0);
    recv_bit(a, rd[0]); check_eq("t5_data_ack", {31'd0, a}, {31'd0, ACK});
    bus_stop();
    check_word(1'b0, 32'h3CA500FF, "t5_word0");
    check_eq("t5_strobes", strobe_cnt, 32'd3);

    // reset during a read while the target pulls SDA
    cpu_write(1'b0, 32'h00000011, 4'h1);
    bus_start();
    send_byte(8'h84, a); check_eq("t6_addr_ack", {31'd0, a}, {31'd0, ACK});
    send_byte(8'h00, a); check_eq("t6_ptr_ack", {31'd0, a}, {31'd0, ACK});
    bus_start();
    send_byte(8'h85, a); check_eq("t6_raddr_ack", {31'd0, a}, {31'd0, ACK});
    wait_neg(6);
    check_eq("t6_oe_before", {31'd0, sda_oe}, 32'd1);
    check_eq("t6_busy_before", {31'd0, busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_oe_reset", {31'd0, sda_oe}, 32'd0);
    check_eq("t6_busy_reset", {31'd0, busy}, 32'd0);
    check_word(1'b0, 32'h0, "t6_word0");
    check_word(1'b1, 32'h0, "t6_word1");
    scl_m = 1'b1; sda_m = 1'b1;
    wait_neg(3);
    rst_n = 1'b1;
    wait_neg(4);
    check_eq("t6_state", 32'(dut.state_r), 32'(IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
